execute_unit: RTL and testbench

Parametrised execute stage for the minuteCore pipeline. It sits between decode/operand-fetch and memory. Single-cycle ALU, branch and jump instructions resolve here. RV-M multiply/divide runs on an iterative radix-2 engine. All results are held in a registered pipeline output that supports stall and flush.

---
 rtl/execute_unit.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_execute_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_unit.sv
// minuteCore execute stage: single-cycle ALU/branch/jump resolution plus an
// iterative radix-2 multiply/divide engine, all feeding one registered output stage.
module execute_unit #(
    parameter int unsigned       XLEN         = 32,
    parameter int unsigned       EX_W         = 4,
    parameter logic [EX_W-1:0]   EXC_MISALIGN = EX_W'(0)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] pc_in,
    input  logic [4:0]      opcode_in,
    input  logic [2:0]      funct3,
    input  logic            variant,
    input  logic            muldiv,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [XLEN-1:0] offset,
    input  logic [4:0]      rd_addr_in,
    input  logic            nop_in,
    input  logic [EX_W-1:0] exc_in,
    input  logic            exc_in_valid,
    input  logic            stall,
    input  logic            flush_in,
    output logic            busy_out,
    output logic            out_valid,
    output logic [4:0]      opcode_out,
    output logic [4:0]      rd_addr_out,
    output logic            nop_out,
    output logic [XLEN-1:0] result,
    output logic [EX_W-1:0] exc_out,
    output logic            exc_out_valid,
    output logic            flush_out,
    output logic [XLEN-1:0] flush_addr
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam logic [4:0] OPC_OP_IMM = 5'b00100, OPC_OP   = 5'b01100, OPC_LUI    = 5'b01101,
                           OPC_AUIPC  = 5'b00101, OPC_JAL  = 5'b11011, OPC_JALR   = 5'b11001,
                           OPC_BRANCH = 5'b11000;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic            neg_q, neg_d, rneg_q, rneg_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rd_q, rd_d;

    logic            out_valid_q, out_valid_d, nop_out_q, nop_out_d;
    logic [4:0]      opcode_out_q, opcode_out_d, rd_addr_out_q, rd_addr_out_d;
    logic [XLEN-1:0] result_q, result_d, flush_addr_q, flush_addr_d;
    logic [EX_W-1:0] exc_out_q, exc_out_d;
    logic            exc_out_valid_q, exc_out_valid_d, flush_out_q, flush_out_d;

    logic            bypass, is_md, special, redirect, misalign, taken, accept, start;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] sc_res, target, a_mag, b_mag, md_res;
    logic [SHW-1:0]  shamt;
    logic [XLEN:0]   mul_sum, div_trial;
    logic [2*XLEN-1:0] prod_full, prod_signed;

    // Single-cycle result, redirect target and muldiv special-case detection
    always_comb begin
        bypass   = exc_in_valid | nop_in;
        is_md    = (opcode_in == OPC_OP) & muldiv;
        special  = is_md & funct3[2] &
                   ((op2 == '0) | (!funct3[0] & (op1 == INT_MIN) & (op2 == '1)));
        shamt    = op2[SHW-1:0];
        sc_res   = '0;
        redirect = 1'b0;
        taken    = 1'b0;
        target   = pc_in + offset;
        case (opcode_in)
            OPC_OP_IMM, OPC_OP: begin
                if (is_md) begin
                    if (op2 == '0) sc_res = funct3[1] ? op1 : '1;
                    else           sc_res = funct3[1] ? '0 : op1;
                end else begin
                    case (funct3)
                        3'b000:  sc_res = ((opcode_in == OPC_OP) && variant) ? op1 - op2 : op1 + op2;
                        3'b001:  sc_res = op1 << shamt;
                        3'b010:  sc_res = XLEN'($signed(op1) < $signed(op2));
                        3'b011:  sc_res = XLEN'(op1 < op2);
                        3'b100:  sc_res = op1 ^ op2;
                        3'b101:  sc_res = variant ? XLEN'($signed(op1) >>> shamt) : op1 >> shamt;
                        3'b110:  sc_res = op1 | op2;
                        default: sc_res = op1 & op2;
                    endcase
                end
            end
            OPC_LUI:   sc_res = op2;
            OPC_AUIPC: sc_res = pc_in + op2;
            OPC_JAL: begin
                sc_res   = pc_in + XLEN'(4);
                redirect = 1'b1;
            end
            OPC_JALR: begin
                sc_res   = pc_in + XLEN'(4);
                redirect = 1'b1;
                target   = (op1 + op2) & ~XLEN'(1);
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  taken = (op1 == op2);
                    3'b001:  taken = (op1 != op2);
                    3'b100:  taken = ($signed(op1) <  $signed(op2));
                    3'b101:  taken = ($signed(op1) >= $signed(op2));
                    3'b110:  taken = (op1 <  op2);
                    3'b111:  taken = (op1 >= op2);
                    default: taken = 1'b0;
                endcase
                redirect = taken;
            end
            default: sc_res = '0;
        endcase
        misalign = redirect & (target[1:0] != 2'b00);
    end

    // Operand magnitudes and signs for the iterative engine
    always_comb begin
        a_signed = funct3[2] ? !funct3[0] : ((funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10));
        b_signed = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01);
        a_neg    = a_signed & op1[XLEN-1];
        b_neg    = b_signed & op2[XLEN-1];
        a_mag    = a_neg ? -op1 : op1;
        b_mag    = b_neg ? -op2 : op2;
    end

    // One shift-add / restoring-subtract step and the final sign fix-up
    always_comb begin
        mul_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_trial   = {hi_q, lo_q[XLEN-1]} - {1'b0, m_q};
        prod_full   = {hi_q, lo_q};
        prod_signed = neg_q ? -prod_full : prod_full;
        if (f3_q[2])
            md_res = f3_q[1] ? (rneg_q ? -hi_q : hi_q) : (neg_q ? -lo_q : lo_q);
        else
            md_res = (f3_q == 3'b000) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
    end

    assign accept   = in_valid & !stall & !flush_in & !flush_out_q & (state_q == S_IDLE);
    assign start    = accept & is_md & !special & !bypass;
    assign busy_out = ((state_q == S_IDLE) & in_valid & is_md & !special & !bypass) |
                      (state_q == S_BUSY) | ((state_q == S_DONE) & stall);

    // Next-state and output-register load
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        hi_d            = hi_q;
        lo_d            = lo_q;
        m_d             = m_q;
        neg_d           = neg_q;
        rneg_d          = rneg_q;
        f3_d            = f3_q;
        rd_d            = rd_q;
        out_valid_d     = out_valid_q;
        opcode_out_d    = opcode_out_q;
        rd_addr_out_d   = rd_addr_out_q;
        nop_out_d       = nop_out_q;
        result_d        = result_q;
        exc_out_d       = exc_out_q;
        exc_out_valid_d = exc_out_valid_q;
        flush_out_d     = flush_out_q;
        flush_addr_d    = flush_addr_q;
        if (flush_in) begin
            state_d         = S_IDLE;
            out_valid_d     = 1'b0;
            flush_out_d     = 1'b0;
            exc_out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!stall) begin
                        out_valid_d     = 1'b0;
                        flush_out_d     = 1'b0;
                        exc_out_valid_d = 1'b0;
                    end
                    if (start) begin
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = funct3[2] ? a_mag : b_mag;
                        m_d     = funct3[2] ? b_mag : a_mag;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        f3_d    = funct3;
                        rd_d    = rd_addr_in;
                    end else if (accept) begin
                        out_valid_d     = 1'b1;
                        opcode_out_d    = opcode_in;
                        rd_addr_out_d   = rd_addr_in;
                        nop_out_d       = nop_in;
                        result_d        = bypass ? '0 : sc_res;
                        exc_out_d       = bypass ? exc_in : (misalign ? EXC_MISALIGN : '0);
                        exc_out_valid_d = bypass ? exc_in_valid : misalign;
                        flush_out_d     = !bypass & redirect & !misalign;
                        flush_addr_d    = (!bypass & redirect & !misalign) ? target : '0;
                    end
                end
                S_BUSY: begin
                    if (f3_q[2]) begin
                        hi_d = div_trial[XLEN] ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : div_trial[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], !div_trial[XLEN]};
                    end else begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + SHW'(1);
                    if (cnt_q == SHW'(XLEN-1)) state_d = S_DONE;
                end
                default: begin
                    if (!stall) begin
                        state_d         = S_IDLE;
                        out_valid_d     = 1'b1;
                        opcode_out_d    = OPC_OP;
                        rd_addr_out_d   = rd_q;
                        nop_out_d       = 1'b0;
                        result_d        = md_res;
                        exc_out_d       = '0;
                        exc_out_valid_d = 1'b0;
                        flush_out_d     = 1'b0;
                        flush_addr_d    = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            hi_q            <= '0;
            lo_q            <= '0;
            m_q             <= '0;
            neg_q           <= 1'b0;
            rneg_q          <= 1'b0;
            f3_q            <= '0;
            rd_q            <= '0;
            out_valid_q     <= 1'b0;
            opcode_out_q    <= '0;
            rd_addr_out_q   <= '0;
            nop_out_q       <= 1'b0;
            result_q        <= '0;
            exc_out_q       <= '0;
            exc_out_valid_q <= 1'b0;
            flush_out_q     <= 1'b0;
            flush_addr_q    <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            hi_q            <= hi_d;
            lo_q            <= lo_d;
            m_q             <= m_d;
            neg_q           <= neg_d;
            rneg_q          <= rneg_d;
            f3_q            <= f3_d;
            rd_q            <= rd_d;
            out_valid_q     <= out_valid_d;
            opcode_out_q    <= opcode_out_d;
            rd_addr_out_q   <= rd_addr_out_d;
            nop_out_q       <= nop_out_d;
            result_q        <= result_d;
            exc_out_q       <= exc_out_d;
            exc_out_valid_q <= exc_out_valid_d;
            flush_out_q     <= flush_out_d;
            flush_addr_q    <= flush_addr_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign opcode_out    = opcode_out_q;
    assign rd_addr_out   = rd_addr_out_q;
    assign nop_out       = nop_out_q;
    assign result        = result_q;
    assign exc_out       = exc_out_q;
    assign exc_out_valid = exc_out_valid_q;
    assign flush_out     = flush_out_q;
    assign flush_addr    = flush_addr_q;
endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: ALU, muldiv latency/results, special cases,
// jumps/branches, bypass, stall and flush behaviour.
module tb_execute_unit;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100, OPC_OP   = 5'b01100, OPC_LUI    = 5'b01101,
                           OPC_AUIPC  = 5'b00101, OPC_JAL  = 5'b11011, OPC_JALR   = 5'b11001,
                           OPC_BRANCH = 5'b11000;

    logic        clk = 1'b0;
    logic        reset, in_valid, variant, muldiv, nop_in, exc_in_valid, stall, flush_in;
    logic [31:0] pc_in, op1, op2, offset;
    logic [4:0]  opcode_in, rd_addr_in;
    logic [2:0]  funct3;
    logic [3:0]  exc_in;
    logic        busy_out, out_valid, nop_out, exc_out_valid, flush_out;
    logic [4:0]  opcode_out, rd_addr_out;
    logic [31:0] result, flush_addr;
    logic [3:0]  exc_out;

    int tests_run    = 0;
    int tests_failed = 0;

    execute_unit #(.XLEN(32), .EX_W(4), .EXC_MISALIGN(4'd0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pc_in(pc_in), .opcode_in(opcode_in),
        .funct3(funct3), .variant(variant), .muldiv(muldiv), .op1(op1), .op2(op2),
        .offset(offset), .rd_addr_in(rd_addr_in), .nop_in(nop_in), .exc_in(exc_in),
        .exc_in_valid(exc_in_valid), .stall(stall), .flush_in(flush_in), .busy_out(busy_out),
        .out_valid(out_valid), .opcode_out(opcode_out), .rd_addr_out(rd_addr_out),
        .nop_out(nop_out), .result(result), .exc_out(exc_out), .exc_out_valid(exc_out_valid),
        .flush_out(flush_out), .flush_addr(flush_addr)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        in_valid = 0; nop_in = 0; exc_in_valid = 0; exc_in = 0; muldiv = 0; variant = 0;
        opcode_in = 0; funct3 = 0; op1 = 0; op2 = 0; offset = 0; pc_in = 0; rd_addr_in = 0;
    endtask

    task automatic drive(input logic [4:0] opc, input logic [2:0] f3, input logic v,
                         input logic md, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] off, input logic [31:0] pc, input logic [4:0] rd);
        in_valid = 1; opcode_in = opc; funct3 = f3; variant = v; muldiv = md;
        op1 = a; op2 = b; offset = off; pc_in = pc; rd_addr_in = rd;
    endtask

    // Issues a muldiv, holds it while busy, returns result, edges-to-valid and busy cycles
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cyc);
        drive(OPC_OP, f3, 1'b0, 1'b1, a, b, 0, 32'h400, 5'd7);
        lat = 0; busy_cyc = 0;
        while (lat < 100) begin
            #1;
            if (busy_out) busy_cyc++;
            step();
            lat++;
            if (out_valid) break;
        end
        res = result;
        set_idle();
    endtask

    task automatic test_reset;
        reset = 1; stall = 0; flush_in = 0; set_idle();
        step(); step();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        tests_run++; if (result !== 32'h0) begin tests_failed++; $display("FAIL reset_result got %h exp 0", result); end
        tests_run++; if (flush_out !== 1'b0 || exc_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_flush_exc got %0b/%0b exp 0/0", flush_out, exc_out_valid); end
        tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b exp 0", busy_out); end
        reset = 0;
        step();
    endtask

    task automatic test_alu;
        logic [4:0]  opc [10] = '{OPC_OP, OPC_OP, OPC_OP, OPC_OP, OPC_OP, OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_OP_IMM};
        logic [2:0]  f3  [10] = '{3'b000, 3'b000, 3'b101, 3'b010, 3'b011, 3'b001, 3'b101, 3'b000, 3'b000, 3'b000};
        logic        v   [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] a   [10] = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h0, 32'h0, 32'h5};
        logic [31:0] b   [10] = '{32'h1, 32'h1, 32'h4, 32'h1, 32'h1, 32'h3F, 32'h4, 32'h12345000, 32'h2000, 32'h3};
        logic [31:0] e   [10] = '{32'h0, 32'hFFFFFFFF, 32'hF8000000, 32'h1, 32'h0, 32'h80000000, 32'h08000000, 32'h12345000, 32'h3000, 32'h8};
        for (int i = 0; i < 10; i++) begin
            drive(opc[i], f3[i], v[i], 1'b0, a[i], b[i], 0, 32'h1000, 5'(i + 1));
            step();
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL alu%0d_valid got %0b exp 1", i, out_valid); end
            tests_run++; if (result !== e[i]) begin tests_failed++; $display("FAIL alu%0d_result got %h exp %h", i, result, e[i]); end
            tests_run++; if (rd_addr_out !== 5'(i + 1)) begin tests_failed++; $display("FAIL alu%0d_rd got %0d exp %0d", i, rd_addr_out, i + 1); end
        end
        set_idle();
        step();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL alu_idle_valid got %0b exp 0", out_valid); end
    endtask

    task automatic test_muldiv;
        logic [2:0]  f3 [8] = '{3'b011, 3'b100, 3'b110, 3'b000, 3'b010, 3'b001, 3'b101, 3'b111};
        logic [31:0] a  [8] = '{32'hFFFFFFFF, 32'd7, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100};
        logic [31:0] b  [8] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7};
        logic [31:0] e  [8] = '{32'd1, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'd0, 32'd14, 32'd2};
        logic [31:0] res;
        int lat, bc;
        for (int i = 0; i < 8; i++) begin
            run_md(f3[i], a[i], b[i], res, lat, bc);
            tests_run++; if (res !== e[i]) begin tests_failed++; $display("FAIL md%0d_result got %h exp %h", i, res, e[i]); end
            tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL md%0d_latency got %0d edges exp 34", i, lat); end
            tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL md%0d_busy got %0d cycles exp 33", i, bc); end
        end
        tests_run++; if (rd_addr_out !== 5'd7 || opcode_out !== OPC_OP) begin tests_failed++; $display("FAIL md_rd_opc got %0d/%b exp 7/%b", rd_addr_out, opcode_out, OPC_OP); end
        step();
    endtask

    task automatic test_special;
        logic [2:0]  f3 [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] a  [4] = '{32'd1234, 32'd1234, 32'h80000000, 32'h80000000};
        logic [31:0] b  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e  [4] = '{32'hFFFFFFFF, 32'd1234, 32'h80000000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            drive(OPC_OP, f3[i], 1'b0, 1'b1, a[i], b[i], 0, 0, 5'd3);
            #1;
            tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL sp%0d_busy got %0b exp 0", i, busy_out); end
            step();
            tests_run++; if (out_valid !== 1'b1 || result !== e[i]) begin tests_failed++; $display("FAIL sp%0d_result got v%0b %h exp v1 %h", i, out_valid, result, e[i]); end
        end
        set_idle();
        step();
    endtask

    task automatic test_jump_branch;
        logic [2:0]  f3 [7] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
        logic [31:0] a  [7] = '{32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
        logic [31:0] b  [7] = '{32'd5, 32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 32'd9};
        logic        tk [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        drive(OPC_JAL, 3'b000, 1'b0, 1'b0, 0, 0, 32'h20, 32'h100, 5'd1);
        step();
        tests_run++; if (result !== 32'h104) begin tests_failed++; $display("FAIL jal_result got %h exp 104", result); end
        tests_run++; if (flush_out !== 1'b1 || flush_addr !== 32'h120) begin tests_failed++; $display("FAIL jal_flush got %0b %h exp 1 120", flush_out, flush_addr); end
        drive(OPC_OP, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 0, 32'h104, 5'd2);
        step();
        tests_run++; if (out_valid !== 1'b0 || flush_out !== 1'b0) begin tests_failed++; $display("FAIL jal_bubble got v%0b f%0b exp v0 f0", out_valid, flush_out); end
        drive(OPC_JALR, 3'b000, 1'b0, 1'b0, 32'h100, 32'h2, 0, 32'h300, 5'd1);
        step();
        tests_run++; if (exc_out_valid !== 1'b1 || exc_out !== 4'd0 || flush_out !== 1'b0) begin tests_failed++; $display("FAIL jalr_misalign got ev%0b e%0d f%0b exp ev1 e0 f0", exc_out_valid, exc_out, flush_out); end
        for (int i = 0; i < 7; i++) begin
            drive(OPC_BRANCH, f3[i], 1'b0, 1'b0, a[i], b[i], 32'h10, 32'h200, 5'd0);
            step();
            tests_run++; if (flush_out !== tk[i] || result !== 32'h0) begin tests_failed++; $display("FAIL br%0d got f%0b r%h exp f%0b r0", i, flush_out, result, tk[i]); end
            tests_run++; if (tk[i] && flush_addr !== 32'h210) begin tests_failed++; $display("FAIL br%0d_addr got %h exp 210", i, flush_addr); end
            set_idle();
            step();
        end
        drive(OPC_BRANCH, 3'b000, 1'b0, 1'b0, 32'd3, 32'd3, 32'h12, 32'h200, 5'd0);
        step();
        tests_run++; if (exc_out_valid !== 1'b1 || flush_out !== 1'b0) begin tests_failed++; $display("FAIL br_misalign got ev%0b f%0b exp ev1 f0", exc_out_valid, flush_out); end
        set_idle();
        step();
    endtask

    task automatic test_bypass;
        drive(OPC_OP, 3'b000, 1'b0, 1'b0, 32'd5, 32'd6, 0, 0, 5'd4);
        nop_in = 1;
        step();
        tests_run++; if (out_valid !== 1'b1 || nop_out !== 1'b1 || result !== 32'h0) begin tests_failed++; $display("FAIL byp_nop got v%0b n%0b r%h exp v1 n1 r0", out_valid, nop_out, result); end
        drive(OPC_JAL, 3'b000, 1'b0, 1'b0, 0, 0, 32'h40, 32'h100, 5'd1);
        nop_in = 0; exc_in_valid = 1; exc_in = 4'd5;
        step();
        tests_run++; if (flush_out !== 1'b0 || exc_out !== 4'd5 || exc_out_valid !== 1'b1 || result !== 32'h0) begin tests_failed++; $display("FAIL byp_exc got f%0b e%0d ev%0b r%h exp f0 e5 ev1 r0", flush_out, exc_out, exc_out_valid, result); end
        set_idle();
        drive(OPC_OP, 3'b100, 1'b0, 1'b1, 32'd9, 32'd3, 0, 0, 5'd4);
        nop_in = 1;
        #1;
        tests_run++; if (busy_out !== 1'b0) begin tests_failed++; $display("FAIL byp_md_busy got %0b exp 0", busy_out); end
        step();
        tests_run++; if (out_valid !== 1'b1 || result !== 32'h0) begin tests_failed++; $display("FAIL byp_md got v%0b r%h exp v1 r0", out_valid, result); end
        set_idle();
        step();
    endtask

    task automatic test_stall;
        drive(OPC_OP, 3'b000, 1'b0, 1'b0, 32'd2, 32'd3, 0, 0, 5'd9);
        step();
        drive(OPC_OP, 3'b000, 1'b0, 1'b0, 32'd10, 32'd20, 0, 0, 5'd10);
        stall = 1;
        step(); step();
        tests_run++; if (out_valid !== 1'b1 || result !== 32'd5 || rd_addr_out !== 5'd9) begin tests_failed++; $display("FAIL stall_hold got v%0b r%0d rd%0d exp v1 r5 rd9", out_valid, result, rd_addr_out); end
        stall = 0;
        step();
        tests_run++; if (result !== 32'd30) begin tests_failed++; $display("FAIL stall_release got %0d exp 30", result); end
        drive(OPC_OP, 3'b000, 1'b0, 1'b1, 32'd6, 32'd7, 0, 0, 5'd11);
        for (int i = 0; i < 33; i++) step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (busy_out !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_done%0d got b%0b v%0b exp b1 v0", i, busy_out, out_valid); end
            step();
        end
        stall = 0;
        step();
        tests_run++; if (out_valid !== 1'b1 || result !== 32'd42 || rd_addr_out !== 5'd11) begin tests_failed++; $display("FAIL stall_done_result got v%0b r%0d rd%0d exp v1 r42 rd11", out_valid, result, rd_addr_out); end
        set_idle();
        step();
    endtask

    task automatic test_flush;
        int seen;
        drive(OPC_OP, 3'b101, 1'b0, 1'b1, 32'd100, 32'd7, 0, 0, 5'd12);
        for (int i = 0; i < 11; i++) step();
        set_idle();
        flush_in = 1;
        step();
        flush_in = 0;
        #1;
        tests_run++; if (busy_out !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_busy got b%0b v%0b exp b0 v0", busy_out, out_valid); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) seen++;
        end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL flush_stray got %0d valid cycles exp 0", seen); end
        drive(OPC_OP, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 0, 0, 5'd13);
        step();
        tests_run++; if (out_valid !== 1'b1 || result !== 32'd2) begin tests_failed++; $display("FAIL flush_recover got v%0b r%0d exp v1 r2", out_valid, result); end
        set_idle();
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_muldiv();
        test_special();
        test_jump_branch();
        test_bypass();
        test_stall();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
